// File: rtl/tdm_demux_8ch.sv
// tdm_demux_8ch
//   Receive side of an 8-channel time-division link. The remote end walks an
//   8:1 mux select through channels 0..7, one channel per clock, and raises a
//   frame marker during channel 0. This block follows the channel index,
//   collects the eight samples into a parallel word and reports framing loss.
//
// Parameters
//   INVERT_IN  : 1 when the link carries the mux's complemented output.
//   MISS_LIMIT : consecutive missing channel-0 markers before lock is dropped
//                (legal range 1..7).
//
// Ports
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   s_n         in   active-low enable; high freezes the block
//   serial_in   in   serial data line from the remote mux
//   frame_sync  in   marker, high during the channel-0 sample
//   q           out  [7:0] last complete frame, q[k] = sample of channel k
//   frame_valid out  one-cycle pulse when q is updated
//   channel     out  [2:0] channel expected at the next sample
//   locked      out  high while locked to the frame
//   sync_error  out  one-cycle pulse on a marker at a nonzero channel

module tdm_demux_8ch #(
  parameter int INVERT_IN  = 0,
  parameter int MISS_LIMIT = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_n,
  input  logic       serial_in,
  input  logic       frame_sync,
  output logic [7:0] q,
  output logic       frame_valid,
  output logic [2:0] channel,
  output logic       locked,
  output logic       sync_error
);

  localparam logic STATE_HUNT   = 1'b0;
  localparam logic STATE_LOCKED = 1'b1;

  localparam logic       INV_BIT   = (INVERT_IN != 0);
  localparam logic [3:0] MISS_LIM4 = 4'(MISS_LIMIT);

  logic       state;
  logic [7:0] shadow;
  logic [2:0] miss;
  logic       sample;
  logic [3:0] miss_next;

  assign sample    = serial_in ^ INV_BIT;
  assign miss_next = {1'b0, miss} + 4'd1;
  assign locked    = (state == STATE_LOCKED);

  // Frame tracker. The pulses default low every enabled or frozen cycle so
  // they never last longer than one clock. A marker at a nonzero channel is
  // checked before frame completion, so a marker on channel 7 aborts the
  // frame instead of delivering it. When markers go missing the tracker
  // flywheels through channel 0 until MISS_LIMIT consecutive misses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= STATE_HUNT;
      channel     <= 3'd0;
      shadow      <= 8'd0;
      miss        <= 3'd0;
      q           <= 8'd0;
      frame_valid <= 1'b0;
      sync_error  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_error  <= 1'b0;
      if (!s_n) begin
        case (state)
          STATE_HUNT: begin
            if (frame_sync) begin
              shadow[0] <= sample;
              channel   <= 3'd1;
              miss      <= 3'd0;
              state     <= STATE_LOCKED;
            end
          end
          default: begin
            if (channel == 3'd0) begin
              if (frame_sync) begin
                shadow[0] <= sample;
                channel   <= 3'd1;
                miss      <= 3'd0;
              end else if (miss_next == MISS_LIM4) begin
                state   <= STATE_HUNT;
                channel <= 3'd0;
                shadow  <= 8'd0;
                miss    <= 3'd0;
              end else begin
                miss      <= miss_next[2:0];
                shadow[0] <= sample;
                channel   <= 3'd1;
              end
            end else if (frame_sync) begin
              sync_error <= 1'b1;
              shadow     <= {7'd0, sample};
              channel    <= 3'd1;
              miss       <= 3'd0;
            end else if (channel == 3'd7) begin
              q           <= {sample, shadow[6:0]};
              frame_valid <= 1'b1;
              channel     <= 3'd0;
            end else begin
              shadow[channel] <= sample;
              channel         <= channel + 3'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_8ch.sv
// tb_tdm_demux_8ch
//   Drives a plain and an inverting instance of tdm_demux_8ch with the same
//   serial stream and compares both against a behavioural frame model.

module tb_tdm_demux_8ch;

  localparam int MISS_LIMIT = 2;

  logic       clk;
  logic       reset_n;
  logic       s_n;
  logic       serial_in;
  logic       frame_sync;
  logic [7:0] q_o [2];
  logic       fv_o [2];
  logic [2:0] ch_o [2];
  logic       lk_o [2];
  logic       se_o [2];

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural reference: index 0 is the plain instance, 1 the inverting one.
  int         m_chan [2];
  int         m_miss [2];
  bit         m_lock [2];
  bit         m_fv   [2];
  bit         m_se   [2];
  bit [7:0]   m_q    [2];
  bit         m_samp [2][8];

  tdm_demux_8ch #(.INVERT_IN(0), .MISS_LIMIT(MISS_LIMIT)) dut (
    .clk(clk), .reset_n(reset_n), .s_n(s_n), .serial_in(serial_in),
    .frame_sync(frame_sync), .q(q_o[0]), .frame_valid(fv_o[0]),
    .channel(ch_o[0]), .locked(lk_o[0]), .sync_error(se_o[0])
  );

  tdm_demux_8ch #(.INVERT_IN(1), .MISS_LIMIT(MISS_LIMIT)) dut_inv (
    .clk(clk), .reset_n(reset_n), .s_n(s_n), .serial_in(serial_in),
    .frame_sync(frame_sync), .q(q_o[1]), .frame_valid(fv_o[1]),
    .channel(ch_o[1]), .locked(lk_o[1]), .sync_error(se_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    else
      n_pass++;
  endtask

  function automatic void modelReset();
    for (int m = 0; m < 2; m++) begin
      m_chan[m] = 0; m_miss[m] = 0; m_lock[m] = 0;
      m_fv[m] = 0; m_se[m] = 0; m_q[m] = 0;
      for (int k = 0; k < 8; k++) m_samp[m][k] = 0;
    end
  endfunction

  // One enabled or frozen clock of the receiver, written from the framing rules.
  function automatic void modelClock(input bit sn, input bit d, input bit fs);
    for (int m = 0; m < 2; m++) begin
      bit b;
      b = d ^ bit'(m);
      m_fv[m] = 0;
      m_se[m] = 0;
      if (sn) continue;
      if (!m_lock[m]) begin
        if (fs) begin
          m_samp[m][0] = b; m_chan[m] = 1; m_miss[m] = 0; m_lock[m] = 1;
        end
      end else if (m_chan[m] == 0) begin
        if (fs) begin
          m_samp[m][0] = b; m_chan[m] = 1; m_miss[m] = 0;
        end else begin
          m_miss[m] = m_miss[m] + 1;
          if (m_miss[m] == MISS_LIMIT) begin
            m_lock[m] = 0; m_chan[m] = 0; m_miss[m] = 0;
            for (int k = 0; k < 8; k++) m_samp[m][k] = 0;
          end else begin
            m_samp[m][0] = b; m_chan[m] = 1;
          end
        end
      end else if (fs) begin
        m_se[m] = 1;
        for (int k = 0; k < 8; k++) m_samp[m][k] = 0;
        m_samp[m][0] = b; m_chan[m] = 1; m_miss[m] = 0;
      end else begin
        m_samp[m][m_chan[m]] = b;
        if (m_chan[m] == 7) begin
          for (int k = 0; k < 8; k++) m_q[m][k] = m_samp[m][k];
          m_fv[m] = 1;
          m_chan[m] = 0;
        end else begin
          m_chan[m] = m_chan[m] + 1;
        end
      end
    end
  endfunction

  task automatic compareAll(input string tag);
    for (int m = 0; m < 2; m++) begin
      checkOutput($sformatf("%s_q%0d", tag, m), q_o[m], m_q[m]);
      checkOutput($sformatf("%s_fv%0d", tag, m), {7'd0, fv_o[m]}, {7'd0, m_fv[m]});
      checkOutput($sformatf("%s_ch%0d", tag, m), {5'd0, ch_o[m]}, 8'(m_chan[m]));
      checkOutput($sformatf("%s_lk%0d", tag, m), {7'd0, lk_o[m]}, {7'd0, m_lock[m]});
      checkOutput($sformatf("%s_se%0d", tag, m), {7'd0, se_o[m]}, {7'd0, m_se[m]});
    end
  endtask

  // Called at a falling edge: drive inputs, take the rising edge, then compare
  // at the next falling edge.
  task automatic applyStimulus(input bit sn, input bit d, input bit fs, input string tag);
    s_n = sn; serial_in = d; frame_sync = fs;
    @(posedge clk);
    modelClock(sn, d, fs);
    @(negedge clk);
    compareAll(tag);
  endtask

  task automatic sendFrame(input logic [7:0] word, input bit marker, input string tag);
    for (int k = 0; k < 8; k++)
      applyStimulus(1'b0, word[k], marker && (k == 0), tag);
  endtask

  initial begin
    s_n = 1'b0; serial_in = 1'b0; frame_sync = 1'b0;
    reset_n = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    compareAll("reset");
    reset_n = 1'b1;

    // Idle line in HUNT: nothing should move without a marker.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'($urandom), 1'b0, "hunt");

    sendFrame(8'hA5, 1'b1, "t1");
    checkOutput("t1_q_const", q_o[0], 8'hA5);
    checkOutput("t1_fv_const", {7'd0, fv_o[0]}, 8'd1);
    checkOutput("t1_lock_const", {7'd0, lk_o[0]}, 8'd1);

    sendFrame(8'h3C, 1'b1, "t2a");
    checkOutput("t2_q3c", q_o[0], 8'h3C);
    sendFrame(8'hC3, 1'b1, "t2b");
    checkOutput("t2_qc3", q_o[0], 8'hC3);

    // Marker re-asserted at channel 4 starts a fresh frame.
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'($urandom), k == 0, "t3a");
    sendFrame(8'h5A, 1'b1, "t3b");
    checkOutput("t3_q5a", q_o[0], 8'h5A);

    // Freeze for three cycles at channel 3.
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, k >= 4, k == 0, "t4a");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'($urandom), 1'($urandom), "t4hold");
    checkOutput("t4_ch_hold", {5'd0, ch_o[0]}, 8'd3);
    for (int k = 3; k < 8; k++) applyStimulus(1'b0, k >= 4, 1'b0, "t4b");
    checkOutput("t4_qf0", q_o[0], 8'hF0);

    // Two missing markers: flywheel once, then drop lock.
    sendFrame(8'h77, 1'b0, "t5a");
    checkOutput("t5_fly_q", q_o[0], 8'h77);
    applyStimulus(1'b0, 1'b1, 1'b0, "t5b");
    checkOutput("t5_unlock", {7'd0, lk_o[0]}, 8'd0);
    checkOutput("t5_q_keep", q_o[0], 8'h77);

    // Inverted link: complement of 96 on the line.
    sendFrame(~8'h96, 1'b1, "t6a");
    checkOutput("t6_inv_q", q_o[1], 8'h96);
    checkOutput("t6_plain_q", q_o[0], 8'h69);

    // Asynchronous reset mid-frame.
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, k == 0, "t6b");
    #2 reset_n = 1'b0;
    #1;
    modelReset();
    compareAll("t6rst");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'($urandom), 1'b0, "t6hunt");
    sendFrame(8'h81, 1'b1, "t6c");
    checkOutput("t6_relock_q", q_o[0], 8'h81);

    // Random traffic: mostly well-framed, with freezes, stray and dropped markers.
    for (int i = 0; i < 600; i++) begin
      bit sn, fs;
      sn = ($urandom_range(0, 9) == 0);
      if (m_chan[0] == 0) fs = ($urandom_range(0, 5) != 0);
      else fs = ($urandom_range(0, 24) == 0);
      applyStimulus(sn, 1'($urandom), fs, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux_8ch.md
Name: tdm_demux_8ch

Overview:
- Receive-side counterpart of the 8:1 data-selector path.
- The transmitter drives a single-bit line from an 8:1 mux whose select (c,b,a) steps through channels 0..7, one channel per clock, with a frame marker on channel 0.
- This block tracks the channel index, deserializes the 8 samples into a parallel word and flags framing loss.
- It sits at the far end of the serial link, feeding parallel consumers.

Parameters:
- INVERT_IN, 0: 1 = link carries the mux's complemented output (W), so the input is inverted before sampling.
- MISS_LIMIT, 2: consecutive missing frame markers at channel 0 before lock is dropped. Legal range 1..7.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- s_n  input  1  active-low enable, same sense as the mux strobe. When high, the block is frozen.
- serial_in  input  1  serial data line from the remote mux.
- frame_sync  input  1  high during the channel-0 sample.
- q  output  8  last complete frame; q[k] is the sample taken at channel k.
- frame_valid  output  1  one-cycle pulse when q is updated.
- channel  output  3  channel index expected at the next sample.
- locked  output  1  high while in LOCKED.
- sync_error  output  1  one-cycle pulse on a marker at a nonzero channel.

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - q=0, frame_valid=0, channel=0, locked=0, sync_error=0.
  - Internal shadow register=0, miss counter=0, state=HUNT.
- Sampled bit = serial_in XOR INVERT_IN. All sampling happens on rising clk.
- s_n=1:
  - State, channel, shadow, miss counter and q hold.
  - frame_valid=0 and sync_error=0.
  - frame_sync and serial_in are ignored.
- HUNT (s_n=0), channel held at 0:
  - frame_sync=0: no change.
  - frame_sync=1: shadow[0]=bit, channel=1, miss=0, go to LOCKED (locked=1 from the next cycle).
- LOCKED (s_n=0), with k = current channel:
  - k=0, frame_sync=1: shadow[0]=bit, channel=1, miss=0.
  - k=0, frame_sync=0: miss+1.
    - If miss+1 = MISS_LIMIT: go to HUNT; locked=0, channel=0, shadow=0, miss=0.
    - Otherwise flywheel: shadow[0]=bit, channel=1.
  - k in 1..6, frame_sync=0: shadow[k]=bit, channel=k+1.
  - k=7, frame_sync=0:
    - q = {bit, shadow[6:0]}, frame_valid=1 for exactly one cycle, channel wraps to 0.
    - Shadow need not be cleared.
  - k in 1..7, frame_sync=1:
    - sync_error=1 for one cycle; the partial frame is discarded (no frame_valid).
    - shadow=0 with shadow[0]=bit, channel=1, miss=0. Stay in LOCKED.
    - A marker at k=7 takes priority over frame completion.
- Latency: q and frame_valid update on the edge that samples channel 7, so they are visible in the cycle after that sample.
- q holds between completions, including through HUNT.
- frame_valid and sync_error are never high in the same cycle.
- Back-to-back frames: every 8th enabled cycle completes a frame; there are no idle cycles.
- Reset asserted mid-frame aborts immediately. After release, the block waits in HUNT for a marker.

Test Plan:
1. Reset, then send frame_sync at channel 0 with bits (ch0..ch7) = 1,0,1,0,0,1,0,1 -> q=8'hA5; frame_valid high exactly one cycle after the channel-7 edge; locked=1; channel sequence 1..7,0.
2. Continuous frames 8'h3C then 8'hC3, marker each frame -> two frame_valid pulses 8 cycles apart; q=3C then C3; sync_error stays 0.
3. Marker re-asserted at channel 4 mid-frame -> sync_error pulse, no frame_valid for the aborted frame, channel=1 next; the following full frame 8'h5A yields q=5A.
4. Hold s_n=1 for 3 cycles at channel 3 mid-frame 8'hF0 -> channel holds at 3, no pulses, q unchanged; after resume q=F0 after 8 total enabled cycles.
5. MISS_LIMIT=2, marker omitted on two consecutive frames -> first unmarked frame still delivered (flywheel, frame_valid pulses); at the second missed channel 0, locked=0, channel=0, q retains the last value.
6. INVERT_IN=1, line driven with the complement of 8'h96 -> q=8'h96. Assert reset_n=0 mid-frame -> all outputs 0 asynchronously; the block re-locks only on the next marker.
